// File: rtl/qtable_next_hop_select_pkg.sv
// Shared definitions for the Q-table next-hop selection slice.
// Contents: word and fixed-point widths, neighbour-table cap, packet-type
// codes, the selector state encoding and a neighbour-entry record.
package qtable_next_hop_select_pkg;

  localparam int WORD_WIDTH    = 16;
  // Energy and Q-values are unsigned Q2.14: 16'h4000 = 1.0
  localparam int FRAC_W        = 14;
  localparam int MAX_NEIGHBORS = 16;

  typedef enum logic [2:0] {
    PKT_HELLO  = 3'b001,
    PKT_QUPD   = 3'b010,
    PKT_CH_ADV = 3'b011,
    PKT_JOIN   = 3'b100,
    PKT_DATA   = 3'b101
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } sel_state_e;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] source_id;
    logic [WORD_WIDTH-1:0] cluster_id;
    logic [WORD_WIDTH-1:0] energy_left;
    logic [WORD_WIDTH-1:0] qvalue;
  } nbr_entry_t;

endpackage

// File: rtl/qtable_next_hop_select_if.sv
// Bundle of the selector's control, neighbour-bank read bus and result signals.
// master : the environment side (issues en, supplies bank data, reads result)
// slave  : the selector itself (reads en/bank data, drives rd_index/result)
interface qtable_next_hop_select_if;
  import qtable_next_hop_select_pkg::*;

  logic                  en;
  logic [WORD_WIDTH-1:0] neighbor_count;
  logic [WORD_WIDTH-1:0] e_min;
  logic [WORD_WIDTH-1:0] rd_index;
  logic [WORD_WIDTH-1:0] m_source_id;
  logic [WORD_WIDTH-1:0] m_cluster_id;
  logic [WORD_WIDTH-1:0] m_energy_left;
  logic [WORD_WIDTH-1:0] m_qvalue;
  logic [WORD_WIDTH-1:0] best_id;
  logic [WORD_WIDTH-1:0] best_cluster_id;
  logic [WORD_WIDTH-1:0] best_energy;
  logic [WORD_WIDTH-1:0] best_qvalue;
  logic                  found;
  logic                  busy;
  logic                  done;

  modport master (
    output en, neighbor_count, e_min,
    output m_source_id, m_cluster_id, m_energy_left, m_qvalue,
    input  rd_index,
    input  best_id, best_cluster_id, best_energy, best_qvalue,
    input  found, busy, done
  );

  modport slave (
    input  en, neighbor_count, e_min,
    input  m_source_id, m_cluster_id, m_energy_left, m_qvalue,
    output rd_index,
    output best_id, best_cluster_id, best_energy, best_qvalue,
    output found, busy, done
  );

endinterface

// File: rtl/qtable_next_hop_select_qsel_compare.sv
// qsel_compare: combinational eligibility + replacement decision.
// Ports:
//   cand_energy_i / cand_qvalue_i : candidate entry
//   best_energy_i / best_qvalue_i : current best entry
//   e_min_i                       : eligibility energy threshold
//   found_i                       : a best entry is already held
//   take_o                        : candidate should replace the best
// Full ties do not replace, so the earlier entry wins.
module qsel_compare
  import qtable_next_hop_select_pkg::*;
#(
  parameter int W = WORD_WIDTH
) (
  input  logic [W-1:0] cand_energy_i,
  input  logic [W-1:0] cand_qvalue_i,
  input  logic [W-1:0] best_energy_i,
  input  logic [W-1:0] best_qvalue_i,
  input  logic [W-1:0] e_min_i,
  input  logic         found_i,
  output logic         take_o
);

  logic eligible;
  logic q_better;
  logic tie_break;

  always_comb begin
    eligible  = (cand_energy_i >= e_min_i);
    q_better  = (cand_qvalue_i > best_qvalue_i);
    tie_break = (cand_qvalue_i == best_qvalue_i) && (cand_energy_i > best_energy_i);
    take_o    = eligible && (!found_i || q_better || tie_break);
  end

endmodule

// File: rtl/qtable_next_hop_select.sv
// qtable_next_hop_select: scans the neighbour banks on a start pulse and keeps
// the eligible neighbour with the highest Q-value (energy breaks Q ties).
// Ports:
//   clk   : system clock, rising edge
//   nrst  : synchronous active-low reset
//   bus   : slave side of qtable_next_hop_select_if
//           en/neighbor_count/e_min in, rd_index out, bank data in,
//           best_*/found/busy/done out
module qtable_next_hop_select #(
  parameter int WORD_WIDTH    = qtable_next_hop_select_pkg::WORD_WIDTH,
  parameter int MAX_NEIGHBORS = qtable_next_hop_select_pkg::MAX_NEIGHBORS,
  parameter int RD_LAT        = 1
) (
  input  logic                      clk,
  input  logic                      nrst,
  qtable_next_hop_select_if.slave   bus
);
  import qtable_next_hop_select_pkg::*;

  localparam logic [WORD_WIDTH-1:0] NMAX = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] ONE  = WORD_WIDTH'(1);

  sel_state_e state_q, state_d;

  logic [WORD_WIDTH-1:0] n_q, n_d;
  logic [WORD_WIDTH-1:0] emin_q, emin_d;
  logic [WORD_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                  issue_p0_q, issue_p0_d;
  logic [RD_LAT-1:0]     vld_p1_q;
  logic [RD_LAT:0]       vld_chain;
  logic                  clr_best;
  logic [WORD_WIDTH-1:0] n_clamped;

  logic [WORD_WIDTH-1:0] best_id_q, best_cid_q, best_e_q, best_qv_q;
  logic                  found_q;
  logic                  cand_vld;
  logic                  take;

  assign n_clamped = (bus.neighbor_count > NMAX) ? NMAX : bus.neighbor_count;

  // Index-valid tag travels alongside the bank read; the oldest tag marks
  // the word currently presented on m_*.
  assign vld_chain = {vld_p1_q, issue_p0_q};
  assign cand_vld  = vld_p1_q[RD_LAT-1];

  qsel_compare #(.W(WORD_WIDTH)) u_cmp (
    .cand_energy_i (bus.m_energy_left),
    .cand_qvalue_i (bus.m_qvalue),
    .best_energy_i (best_e_q),
    .best_qvalue_i (best_qv_q),
    .e_min_i       (emin_q),
    .found_i       (found_q),
    .take_o        (take)
  );

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      emin_q     <= '0;
      rd_idx_q   <= '0;
      issue_p0_q <= 1'b0;
      vld_p1_q   <= '0;
      best_id_q  <= '0;
      best_cid_q <= '0;
      best_e_q   <= '0;
      best_qv_q  <= '0;
      found_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      emin_q     <= emin_d;
      rd_idx_q   <= rd_idx_d;
      issue_p0_q <= issue_p0_d;
      vld_p1_q   <= vld_chain[RD_LAT-1:0];
      if (clr_best) begin
        best_id_q  <= '0;
        best_cid_q <= '0;
        best_e_q   <= '0;
        best_qv_q  <= '0;
        found_q    <= 1'b0;
      end else if (cand_vld && take) begin
        best_id_q  <= bus.m_source_id;
        best_cid_q <= bus.m_cluster_id;
        best_e_q   <= bus.m_energy_left;
        best_qv_q  <= bus.m_qvalue;
        found_q    <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    emin_d     = emin_q;
    rd_idx_d   = rd_idx_q;
    issue_p0_d = 1'b0;
    clr_best   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          n_d      = n_clamped;
          emin_d   = bus.e_min;
          clr_best = 1'b1;
          if (n_clamped == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_SCAN;
            rd_idx_d   = '0;
            issue_p0_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (rd_idx_q == n_q - ONE) begin
          state_d = ST_DRAIN;
        end else begin
          rd_idx_d   = rd_idx_q + ONE;
          issue_p0_d = 1'b1;
        end
      end
      // Leave once every issued read has returned and been compared; the
      // final best update lands on the edge that empties the pipeline.
      ST_DRAIN: begin
        if (!issue_p0_q && (vld_p1_q == '0)) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.rd_index        = rd_idx_q;
    bus.best_id         = best_id_q;
    bus.best_cluster_id = best_cid_q;
    bus.best_energy     = best_e_q;
    bus.best_qvalue     = best_qv_q;
    bus.found           = found_q;
    bus.busy            = (state_q != ST_IDLE);
    bus.done            = (state_q == ST_FINISH);
  end

endmodule
